scan_sel_gen: RTL and testbench

- Sequential select generator that drives the select/enable inputs of the 3-to-8 one-hot decoder stage directly downstream.
- Steps a 3-bit channel select through the enabled channels of an 8-bit mask.
- Holds each channel active for a programmable dwell and inserts enable-low blanking between channels.
- Used for display/LED scanning and round-robin strobing; supports single-shot sweep and continuous mode.

---
 rtl/scan_pkg.sv | 14 +
 rtl/next_chan_find.sv | 31 +++
 rtl/scan_sel_gen.sv | 134 +++++++++++++
 tb/tb_scan_sel_gen.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/scan_pkg.sv
// Shared types for the channel scan select generator.
// Channel count, select width and FSM state encoding.
package scan_pkg;

    localparam int NCH   = 8;
    localparam int SEL_W = 3;

    typedef enum logic [1:0] {
        IDLE,
        ACTIVE,
        GAP
    } state_t;

endpackage

// File: rtl/next_chan_find.sv
// Finds the next enabled channel above the current select,
// plus the lowest enabled channel for wrap/start.
module next_chan_find
    import scan_pkg::*;
(
    input  logic [NCH-1:0]   mask,
    input  logic [SEL_W-1:0] cur,
    output logic [SEL_W-1:0] nxt,
    output logic [SEL_W-1:0] low,
    output logic             above,
    output logic             any
);

    // Descending scan: the last hit written is the lowest one.
    always_comb begin
        nxt   = '0;
        low   = '0;
        above = 1'b0;
        any   = |mask;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (mask[i]) begin
                low = SEL_W'(i);
                if (i > int'(cur)) begin
                    nxt   = SEL_W'(i);
                    above = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/scan_sel_gen.sv
// Steps a decoder select through enabled mask channels with
// programmable dwell and enable-low blanking between channels.
module scan_sel_gen
    import scan_pkg::*;
#(
    parameter int DWELL_W = 8,
    parameter int BLANK   = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               stop,
    input  logic               cont,
    input  logic [NCH-1:0]     mask,
    input  logic [DWELL_W-1:0] dwell,
    output logic [SEL_W-1:0]   sel,
    output logic               en,
    output logic               busy,
    output logic               done
);

    localparam int GW = (BLANK > 0) ? $clog2(BLANK + 1) : 1;

    state_t             state, state_n;
    logic               cont_q, cont_n;
    logic [DWELL_W-1:0] dcnt, dcnt_n;
    logic [GW-1:0]      gcnt, gcnt_n;
    logic [SEL_W-1:0]   sel_n;
    logic               en_n, busy_n, done_n;
    logic               adv;

    logic [SEL_W-1:0]   nxt, low;
    logic               above, any;

    next_chan_find u_find (
        .mask  (mask),
        .cur   (sel),
        .nxt   (nxt),
        .low   (low),
        .above (above),
        .any   (any)
    );

    // A zero dwell still gives one active cycle.
    function automatic logic [DWELL_W-1:0] dload(
        input logic [DWELL_W-1:0] d
    );
        return (d == '0) ? DWELL_W'(1) : d;
    endfunction

    always_comb begin
        state_n = state;
        cont_n  = cont_q;
        dcnt_n  = dcnt;
        gcnt_n  = gcnt;
        sel_n   = sel;
        done_n  = 1'b0;
        adv     = 1'b0;
        unique case (state)
            IDLE: begin
                if (start && !stop && any) begin
                    state_n = ACTIVE;
                    sel_n   = low;
                    cont_n  = cont;
                    dcnt_n  = dload(dwell);
                end
            end
            ACTIVE: begin
                if (stop) begin
                    state_n = IDLE;
                end else if (dcnt <= DWELL_W'(1)) begin
                    if (BLANK > 0) begin
                        state_n = GAP;
                        gcnt_n  = GW'(BLANK);
                    end else begin
                        adv = 1'b1;
                    end
                end else begin
                    dcnt_n = dcnt - DWELL_W'(1);
                end
            end
            GAP: begin
                if (stop) begin
                    state_n = IDLE;
                end else if (gcnt <= GW'(1)) begin
                    adv = 1'b1;
                end else begin
                    gcnt_n = gcnt - GW'(1);
                end
            end
            default: state_n = IDLE;
        endcase
        // Mask is sampled live at the advance point.
        if (adv) begin
            if (above) begin
                state_n = ACTIVE;
                sel_n   = nxt;
                dcnt_n  = dload(dwell);
            end else if (any && cont_q) begin
                state_n = ACTIVE;
                sel_n   = low;
                dcnt_n  = dload(dwell);
            end else begin
                state_n = IDLE;
                done_n  = 1'b1;
            end
        end
        en_n   = (state_n == ACTIVE);
        busy_n = (state_n != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            cont_q <= 1'b0;
            dcnt   <= '0;
            gcnt   <= '0;
            sel    <= '0;
            en     <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            state  <= state_n;
            cont_q <= cont_n;
            dcnt   <= dcnt_n;
            gcnt   <= gcnt_n;
            sel    <= sel_n;
            en     <= en_n;
            busy   <= busy_n;
            done   <= done_n;
        end
    end

endmodule

// File: tb/tb_scan_sel_gen.sv
// Scoreboard bench for scan_sel_gen.
// Plan model pushes expected outputs; monitor compares.
module tb_scan_sel_gen;

  localparam int BLANK = 1;

  logic       clk;
  logic       rst, start, stop, cont;
  logic [7:0] mask;
  logic [7:0] dwell;
  logic [2:0] sel;
  logic       en, busy, done;
  logic       fin = 1'b0;

  scan_sel_gen #(.DWELL_W(8), .BLANK(BLANK)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .stop  (stop),
    .cont  (cont),
    .mask  (mask),
    .dwell (dwell),
    .sel   (sel),
    .en    (en),
    .busy  (busy),
    .done  (done)
  );

  typedef struct packed {
    logic [2:0] sel;
    logic       en;
    logic       busy;
    logic       done;
  } exp_t;

  typedef struct packed {
    logic [2:0] sel;
    logic       en;
  } slot_t;

  exp_t  expq[$];
  slot_t plan[$];
  int    errors = 0;
  int    checks = 0;
  int    cyc    = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int first_above(
    input logic [7:0] m,
    input int from
  );
    for (int i = from + 1; i < 8; i++)
      if (m[i]) return i;
    return -1;
  endfunction

  initial begin : model
    logic       m_busy;
    logic [2:0] m_sel;
    logic       m_cont;
    exp_t       e;
    slot_t      s;
    int         ch, d;
    m_busy = 1'b0;
    m_sel  = '0;
    m_cont = 1'b0;
    forever begin
      @(posedge clk);
      ch = -1;
      e  = '{sel: m_sel, en: 1'b0,
             busy: 1'b0, done: 1'b0};
      if (rst) begin
        plan.delete();
        m_busy = 1'b0;
        m_sel  = '0;
        m_cont = 1'b0;
        e      = '0;
      end else if (!m_busy) begin
        if (start && !stop && mask != 0) begin
          m_cont = cont;
          ch     = first_above(mask, -1);
        end
      end else if (stop) begin
        plan.delete();
        m_busy = 1'b0;
      end else if (plan.size() == 0) begin
        ch = first_above(mask, int'(m_sel));
        if (ch < 0 && m_cont)
          ch = first_above(mask, -1);
        if (ch < 0) begin
          m_busy = 1'b0;
          e.done = 1'b1;
        end
      end
      if (ch >= 0) begin
        d = (dwell == 0) ? 1 : int'(dwell);
        for (int k = 0; k < d; k++)
          plan.push_back('{sel: 3'(ch), en: 1'b1});
        for (int k = 0; k < BLANK; k++)
          plan.push_back('{sel: 3'(ch), en: 1'b0});
        m_busy = 1'b1;
      end
      if (m_busy && plan.size() > 0) begin
        s     = plan.pop_front();
        m_sel = s.sel;
        e     = '{sel: s.sel, en: s.en,
                  busy: 1'b1, done: 1'b0};
      end
      expq.push_back(e);
    end
  end

  initial begin : monitor
    exp_t w;
    forever begin
      @(negedge clk);
      cyc++;
      if (expq.size() > 0) begin
        w = expq.pop_front();
        checks++;
        if ({sel, en, busy, done} !== w) begin
          errors++;
          $display("FAIL out@%0d: got %0d%b%b%b want %0d%b%b%b",
                   cyc, sel, en, busy, done,
                   w.sel, w.en, w.busy, w.done);
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    if (!fin) begin
      errors++;
      $display("FAIL timeout: stimulus did not finish");
      $display("Result: errors=%0d of %0d checks",
               errors, checks);
      $finish;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk_rst();
    checks++;
    if ({sel, en, busy, done} !== 6'b0) begin
      errors++;
      $display("FAIL reset: sel=%0d en=%b busy=%b done=%b",
               sel, en, busy, done);
    end
  endtask

  task automatic go();
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  initial begin : stim
    rst = 1'b1; start = 1'b0; stop = 1'b0;
    cont = 1'b0; mask = '0; dwell = '0;
    tick(2);
    chk_rst();
    rst = 1'b0;
    tick(1);
    mask = 8'hFF; dwell = 8'd2; cont = 1'b0;
    go(); tick(28);
    mask = 8'hA4; dwell = 8'd1; cont = 1'b1;
    go(); tick(14);
    stop = 1'b1; tick(1); stop = 1'b0; tick(2);
    mask = 8'h01; dwell = 8'd0; cont = 1'b0;
    go(); tick(4);
    mask = 8'hFF; dwell = 8'd4; cont = 1'b0;
    go(); tick(16);
    stop = 1'b1; tick(1); stop = 1'b0; tick(2);
    mask = 8'h30; dwell = 8'd1;
    go(); tick(8);
    mask = 8'h00; go(); tick(2);
    mask = 8'h0F; stop = 1'b1; go();
    stop = 1'b0; tick(2);
    dwell = 8'd3; go(); tick(2);
    mask = 8'hF0; cont = 1'b1; go(); mask = 8'h0F;
    tick(20);
    mask = 8'h0F; dwell = 8'd2; cont = 1'b1;
    go(); tick(2); mask = 8'h00; tick(6);
    mask = 8'h0F; go(); tick(3);
    rst = 1'b1; tick(1);
    chk_rst();
    rst = 1'b0; tick(3);
    for (int i = 0; i < 600; i++) begin
      rst   = ($urandom_range(0, 99) == 0);
      start = ($urandom_range(0, 5) == 0);
      stop  = ($urandom_range(0, 31) == 0);
      cont  = 1'($urandom_range(0, 1));
      dwell = 8'($urandom_range(0, 3));
      if ($urandom_range(0, 11) == 0)
        mask = ($urandom_range(0, 3) == 0)
             ? 8'h00 : 8'($urandom);
      tick(1);
    end
    rst = 1'b0; start = 1'b0; stop = 1'b0;
    tick(3);
    fin = 1'b1;
    #2;
    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
